// File: rtl/led_blink_code.sv
// Blink-code LED driver: shows a 4-bit code as N active-low pulses followed by a gap, repeating.
// A new code waits in a one-deep pending slot until the current sequence reaches the end of its gap.
module led_blink_code #(
  parameter int CLK_HZ = 125000000,
  parameter int ON_MS  = 200,
  parameter int OFF_MS = 300,
  parameter int GAP_MS = 1500
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       code_valid,
  input  logic [3:0] code_in,
  output logic       code_ready,
  output logic       led_n,
  output logic       busy
);

  localparam int DIV    = CLK_HZ / 1000;
  localparam int MAX_OF = (ON_MS > OFF_MS) ? ON_MS : OFF_MS;
  localparam int MAX_MS = (MAX_OF > GAP_MS) ? MAX_OF : GAP_MS;
  localparam int PW     = $clog2(DIV + 1);
  localparam int MW     = $clog2(MAX_MS + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [MW-1:0] ON_LAST  = MW'(ON_MS - 1);
  localparam logic [MW-1:0] OFF_LAST = MW'(OFF_MS - 1);
  localparam logic [MW-1:0] GAP_LAST = MW'(GAP_MS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [PW-1:0]   pre_r;
  logic [MW-1:0]   ms_r;
  logic [MW-1:0]   ms_last_s;
  logic [3:0]      active_code_r, active_code_s;
  logic [3:0]      pulses_left_r, pulses_left_s;
  logic [3:0]      pending_r, pending_s;
  logic            pending_valid_r, pending_valid_s;
  logic            consume_r, consume_s;
  logic            led_n_r, busy_r;
  logic            accept_s, expire_s;

  assign accept_s   = code_valid & ~pending_valid_r;
  assign code_ready = ~pending_valid_r;
  assign led_n      = led_n_r;
  assign busy       = busy_r;

  // Last ms index of the current state and the resulting expiry strobe
  always_comb begin
    ms_last_s = {MW{1'b0}};
    case (state_r)
      S_ON:    ms_last_s = ON_LAST;
      S_OFF:   ms_last_s = OFF_LAST;
      S_GAP:   ms_last_s = GAP_LAST;
      default: ms_last_s = {MW{1'b0}};
    endcase
    expire_s = (state_r != S_IDLE) && (pre_r == PRE_LAST) && (ms_r == ms_last_s);
  end

  // Next-state, sequence bookkeeping and pending-slot control
  always_comb begin
    state_s         = state_r;
    active_code_s   = active_code_r;
    pulses_left_s   = pulses_left_r;
    pending_s       = pending_r;
    pending_valid_s = pending_valid_r;
    consume_s       = 1'b0;
    // The slot is released one cycle after its code was taken at gap expiry
    if (consume_r) begin
      pending_valid_s = 1'b0;
    end else begin
      pending_valid_s = pending_valid_r;
    end
    case (state_r)
      S_IDLE: begin
        if (accept_s && (code_in != 4'd0)) begin
          active_code_s = code_in;
          pulses_left_s = code_in;
          state_s       = S_ON;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ON: begin
        if (expire_s && (pulses_left_r > 4'd1)) begin
          pulses_left_s = pulses_left_r - 4'd1;
          state_s       = S_OFF;
        end else if (expire_s) begin
          state_s = S_GAP;
        end else begin
          state_s = S_ON;
        end
      end
      S_OFF: begin
        if (expire_s) begin
          state_s = S_ON;
        end else begin
          state_s = S_OFF;
        end
      end
      S_GAP: begin
        if (expire_s && pending_valid_r) begin
          consume_s = 1'b1;
          if (pending_r != 4'd0) begin
            active_code_s = pending_r;
            pulses_left_s = pending_r;
            state_s       = S_ON;
          end else begin
            state_s = S_IDLE;
          end
        end else if (expire_s) begin
          pulses_left_s = active_code_r;
          state_s       = S_ON;
        end else begin
          state_s = S_GAP;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    if (accept_s && (state_r != S_IDLE)) begin
      pending_s       = code_in;
      pending_valid_s = 1'b1;
    end else begin
      pending_s = pending_s;
    end
  end

  // State, sequence registers and registered LED/busy outputs
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= S_IDLE;
      active_code_r   <= 4'd0;
      pulses_left_r   <= 4'd0;
      pending_r       <= 4'd0;
      pending_valid_r <= 1'b0;
      consume_r       <= 1'b0;
      led_n_r         <= 1'b1;
      busy_r          <= 1'b0;
    end else begin
      state_r         <= state_s;
      active_code_r   <= active_code_s;
      pulses_left_r   <= pulses_left_s;
      pending_r       <= pending_s;
      pending_valid_r <= pending_valid_s;
      consume_r       <= consume_s;
      led_n_r         <= (state_s != S_ON);
      busy_r          <= (state_s != S_IDLE);
    end
  end

  // ms prescaler and phase counter, both cleared on every state entry
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      pre_r <= {PW{1'b0}};
      ms_r  <= {MW{1'b0}};
    end else if ((state_s != state_r) || (state_r == S_IDLE)) begin
      pre_r <= {PW{1'b0}};
      ms_r  <= {MW{1'b0}};
    end else if (pre_r == PRE_LAST) begin
      pre_r <= {PW{1'b0}};
      ms_r  <= ms_r + {{(MW-1){1'b0}}, 1'b1};
    end else begin
      pre_r <= pre_r + {{(PW-1){1'b0}}, 1'b1};
      ms_r  <= ms_r;
    end
  end

endmodule
